// File: rtl/mult_hilo_ctrl.sv
// Sequencer for the 32-cycle signed multiplier plus the architectural HI/LO pair.
// Handles MULT issue/capture, MTHI/MTLO writes and the MFHI/MFLO read port.
module mult_hilo_ctrl #(
    parameter int RUN_CYCLES = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opStart,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        mthiWr,
    input  logic        mtloWr,
    input  logic [31:0] wrData,
    input  logic        readSel,
    output logic [31:0] readData,
    output logic        busy,
    output logic        done,
    output logic        multErr,
    output logic        multInit,
    output logic [31:0] multA,
    output logic [31:0] multB,
    input  logic        multStop,
    input  logic [31:0] multHi,
    input  logic [31:0] multLo,
    output logic [31:0] hiReg,
    output logic [31:0] loReg
);

    localparam int CW = $clog2(RUN_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPTURE
    } state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            multA   <= '0;
            multB   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            done    <= 1'b0;
            multErr <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (opStart) begin
                        multA <= opA;
                        multB <= opB;
                        cnt   <= '0;
                    end
                    if (mthiWr) hiReg <= wrData;
                    if (mtloWr) loReg <= wrData;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                end
                CAPTURE: begin
                    hiReg <= multHi;
                    loReg <= multLo;
                    done  <= 1'b1;
                    // multStop should already be set; a miss is a stuck flag
                    if (!multStop) multErr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        multInit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (opStart) state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                multInit = 1'b1;
                if (cnt == LAST) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // extra multInit cycle clears the multiplier's end flag
                busy      = 1'b1;
                multInit  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign readData = readSel ? hiReg : loReg;

endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

Sequencer and HI/LO register file between the multicycle control unit and the 32-cycle signed multiplier (`mult`). It accepts a one-cycle MULT request and registers the operands. It drives `multInit` for exactly the window the multiplier needs, captures `hi`/`lo` into the architectural HI/LO registers, and signals completion. It also services MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
Parameters:
- `RUN_CYCLES`, default 34. Number of RUN cycles: 1 load, 32 iterations, 1 result cycle.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock, shared with `mult`.
- `opStart`  in  1  one-cycle MULT request from the control unit.
- `opA`, `opB`  in  32  signed operands (rs, rt), sampled with `opStart`.
- `mthiWr`, `mtloWr`  in  1  write strobes for HI and LO.
- `wrData`  in  32  data for MTHI/MTLO.
- `readSel`  in  1  read select: 0 selects LO, 1 selects HI.
- `readData`  out  32  combinational read of the selected register.
- `busy`  out  1  high while a multiply is in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new product.
- `multErr`  out  1  sticky error flag; set when `multStop` is low at capture.
- `multInit`  out  1  to `mult.multInit`.
- `multA`, `multB`  out  32  to `mult.entradaA` / `entradaB`; registered operands.
- `multStop`  in  1  from `mult.multStop`.
- `multHi`, `multLo`  in  32  from `mult.hi` / `mult.lo`.
- `hiReg`, `loReg`  out  32  architectural HI and LO.

## Operation
- FSM states: IDLE, RUN, CAPTURE.
- IDLE
  - `busy`=0, `multInit`=0.
  - When `opStart`=1: latch `opA`/`opB` into `multA`/`multB`, clear `cnt`, go to RUN.
- RUN
  - `multInit`=1, `busy`=1, `cnt` increments each cycle.
  - When `cnt`==RUN_CYCLES-1, go to CAPTURE.
- CAPTURE
  - `multInit`=1 for one extra cycle. This clears the multiplier's internal end-of-operation flag so its next load cycle starts aligned.
  - At the exit edge: `hiReg`<=`multHi`, `loReg`<=`multLo`, `done`<=1. If `multStop`==0, `multErr`<=1.
  - Go to IDLE.
- Total `multInit` high time per operation: exactly RUN_CYCLES+1 = 35 consecutive cycles.
- `multStop` is sticky in the multiplier once set. It is used only for the CAPTURE sanity check, never for sequencing.
- `multA`/`multB` hold their value from the latch edge until the next accepted `opStart`.
- MTHI/MTLO:
  - Accepted only in IDLE, written at the edge.
  - `mthiWr` and `mtloWr` together write `wrData` to both registers.
  - Writes while `busy`=1 are ignored.
- `opStart` while `busy`=1 is ignored; the control unit stalls on `busy`.
- `opStart` together with a write in IDLE: the write lands now; the product overwrites HI/LO at capture.
- `readData` is combinational from `hiReg`/`loReg`. It returns the old values during `busy`.
- Arithmetic: none in this block. The product is the full 64-bit two's-complement result, {HI, LO}.

## Timing
- Reset values: `hiReg`=0, `loReg`=0, `multA`=0, `multB`=0, `busy`=0, `done`=0, `multInit`=0, `multErr`=0, state IDLE, `cnt`=0.
- Let E0 be the edge that samples `opStart`.
  - `busy` and `multInit` are high in cycles E0+1 … E0+35.
  - HI/LO update at edge E0+35.
  - `done`=1 and `busy`=0 in cycle E0+35 … E0+36 (one cycle).
- Back-to-back operation: a new `opStart` may be sampled in the `done` cycle. In that case `multInit` is low for exactly 1 cycle between operations.
- Reset mid-operation: at the next edge the block returns to IDLE, `multInit`=0, HI/LO=0, and no `done` pulse is produced. The multiplier is reset by the same edge.
- `done` is never high in the same cycle as `busy`.

## Test plan
- Reset, then `opStart` with A=3, B=5 (real `mult` instance).
  - `multInit` is high exactly 35 cycles.
  - `done` is a single pulse 35 cycles after E0.
  - Result: `hiReg`=0x00000000, `loReg`=0x0000000F, `multErr`=0.
- A=0xFFFFFFFF, B=2 → `hiReg`=0xFFFFFFFF, `loReg`=0xFFFFFFFE.
- Back-to-back:
  - First operation A=7, B=6 → LO=42.
  - Second `opStart` in the `done` cycle with A=0x80000000, B=0x80000000 → HI=0x40000000, LO=0.
  - Second operation shows the same 35-cycle latency.
- MTHI/MTLO and reads:
  - In IDLE, `mthiWr` with 0xDEADBEEF, then `mtloWr` with 0x12345678. `readSel`=1/0 returns those values.
  - `mthiWr` of 0x1 while `busy` → ignored; HI then takes the product.
- Reset asserted at RUN cycle 10 → next cycle `busy`=0, `multInit`=0, HI=LO=0, no `done`. A following A=−4, B=−4 operation gives LO=16, HI=0.
- Multiplier stub with `multStop` tied 0 → `multErr`=1 after CAPTURE and stays 1 across later operations until `reset`.
